// File: rtl/dilithium_pkg.sv
// Shared ML-DSA constants, parameter sets and the ExpandA sequencer state type.
package dilithium_pkg;

    localparam int unsigned Q         = 8380417;
    localparam int unsigned N         = 256;
    localparam int unsigned RHO_BITS  = 256;
    localparam int unsigned SEED_BITS = RHO_BITS + 16;

    // Matrix dimensions (rows K, columns L) per ML-DSA parameter set
    localparam int unsigned MLDSA44_K = 4;
    localparam int unsigned MLDSA44_L = 4;
    localparam int unsigned MLDSA65_K = 6;
    localparam int unsigned MLDSA65_L = 5;
    localparam int unsigned MLDSA87_K = 8;
    localparam int unsigned MLDSA87_L = 7;

    typedef enum logic [2:0] {
        EA_IDLE   = 3'd0,
        EA_INIT   = 3'd1,
        EA_LAUNCH = 3'd2,
        EA_WAIT   = 3'd3,
        EA_ADV    = 3'd4,
        EA_FIN    = 3'd5
    } expand_a_state_e;

    // Sampler seed rho || s || r, byte i at bits 8i+7:8i
    function automatic logic [SEED_BITS-1:0] expand_a_seed(
        input logic [RHO_BITS-1:0] rho,
        input logic [3:0]          r,
        input logic [3:0]          s
    );
        return {8'(r), 8'(s), rho};
    endfunction

endpackage

// File: rtl/expand_a_ctrl.sv
// ExpandA sequencer: walks (r,s) over the k_dim x l_dim matrix, re-initialising
// SHAKE128 and launching the rejection sampler once per polynomial.
module expand_a_ctrl
    import dilithium_pkg::*;
#(
    parameter int unsigned K                = MLDSA87_K,
    parameter int unsigned L                = MLDSA87_L,
    parameter int unsigned SHAKE_RST_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RHO_BITS-1:0]  rho,
    input  logic [3:0]           k_dim,
    input  logic [3:0]           l_dim,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 shake_init,
    output logic                 poly_start,
    output logic [SEED_BITS-1:0] poly_seed,
    output logic [3:0]           poly_k,
    output logic [3:0]           poly_l,
    input  logic                 poly_done
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IC_W = $clog2(SHAKE_RST_CYCLES + 1);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(SHAKE_RST_CYCLES - 1);

    expand_a_state_e      state, state_nxt;
    logic [RHO_BITS-1:0]  rho_q, rho_nxt;
    logic [3:0]           kd_q, kd_nxt;
    logic [3:0]           ld_q, ld_nxt;
    logic [3:0]           r_q, r_nxt;
    logic [3:0]           s_q, s_nxt;
    logic [WD_W-1:0]      wd_q, wd_nxt;
    logic [IC_W-1:0]      ic_q, ic_nxt;

    logic                 busy_nxt, done_nxt, error_nxt;
    logic                 shake_init_nxt, poly_start_nxt;
    logic [SEED_BITS-1:0] poly_seed_nxt;
    logic [3:0]           poly_k_nxt, poly_l_nxt;

    logic                 dims_ok_c;

    assign dims_ok_c = (k_dim != 4'd0) && (k_dim <= 4'(K)) &&
                       (l_dim != 4'd0) && (l_dim <= 4'(L));

    // State, counters and all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EA_IDLE;
            rho_q      <= '0;
            kd_q       <= '0;
            ld_q       <= '0;
            r_q        <= '0;
            s_q        <= '0;
            wd_q       <= '0;
            ic_q       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            shake_init <= 1'b0;
            poly_start <= 1'b0;
            poly_seed  <= '0;
            poly_k     <= '0;
            poly_l     <= '0;
        end else begin
            state      <= state_nxt;
            rho_q      <= rho_nxt;
            kd_q       <= kd_nxt;
            ld_q       <= ld_nxt;
            r_q        <= r_nxt;
            s_q        <= s_nxt;
            wd_q       <= wd_nxt;
            ic_q       <= ic_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            shake_init <= shake_init_nxt;
            poly_start <= poly_start_nxt;
            poly_seed  <= poly_seed_nxt;
            poly_k     <= poly_k_nxt;
            poly_l     <= poly_l_nxt;
        end
    end

    // Next-state and next-output logic; seed/indices are loaded on every entry to INIT
    always_comb begin
        state_nxt      = state;
        rho_nxt        = rho_q;
        kd_nxt         = kd_q;
        ld_nxt         = ld_q;
        r_nxt          = r_q;
        s_nxt          = s_q;
        wd_nxt         = wd_q;
        ic_nxt         = ic_q;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        error_nxt      = 1'b0;
        shake_init_nxt = shake_init;
        poly_start_nxt = 1'b0;
        poly_seed_nxt  = poly_seed;
        poly_k_nxt     = poly_k;
        poly_l_nxt     = poly_l;

        case (state)
            EA_IDLE: begin
                shake_init_nxt = 1'b0;
                if (start) begin
                    if (dims_ok_c) begin
                        rho_nxt        = rho;
                        kd_nxt         = k_dim;
                        ld_nxt         = l_dim;
                        r_nxt          = 4'd0;
                        s_nxt          = 4'd0;
                        ic_nxt         = '0;
                        busy_nxt       = 1'b1;
                        shake_init_nxt = 1'b1;
                        poly_seed_nxt  = expand_a_seed(rho, 4'd0, 4'd0);
                        poly_k_nxt     = 4'd0;
                        poly_l_nxt     = 4'd0;
                        state_nxt      = EA_INIT;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end

            EA_INIT: begin
                ic_nxt = ic_q + IC_W'(1);
                if (ic_q == IC_LAST) begin
                    shake_init_nxt = 1'b0;
                    poly_start_nxt = 1'b1;
                    wd_nxt         = '0;
                    state_nxt      = EA_LAUNCH;
                end
            end

            EA_LAUNCH: begin
                wd_nxt    = wd_q + WD_W'(1);
                state_nxt = EA_WAIT;
            end

            EA_WAIT: begin
                if (poly_done) begin
                    state_nxt = EA_ADV;
                end else if (wd_q == WD_LAST) begin
                    error_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = EA_IDLE;
                end else if (wd_q != WD_MAX) begin
                    wd_nxt = wd_q + WD_W'(1);
                end
            end

            EA_ADV: begin
                if (s_q == ld_q - 4'd1 && r_q == kd_q - 4'd1) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = EA_FIN;
                end else begin
                    if (s_q == ld_q - 4'd1) begin
                        s_nxt = 4'd0;
                        r_nxt = r_q + 4'd1;
                    end else begin
                        s_nxt = s_q + 4'd1;
                    end
                    ic_nxt         = '0;
                    shake_init_nxt = 1'b1;
                    poly_seed_nxt  = expand_a_seed(rho_q, r_nxt, s_nxt);
                    poly_k_nxt     = r_nxt;
                    poly_l_nxt     = s_nxt;
                    state_nxt      = EA_INIT;
                end
            end

            EA_FIN: begin
                state_nxt = EA_IDLE;
            end

            default: begin
                busy_nxt  = 1'b0;
                state_nxt = EA_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_expand_a_ctrl.sv
// Directed bench for expand_a_ctrl with a stub sampler of programmable latency.
module tb_expand_a_ctrl;

    localparam int unsigned TO = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] rho;
    logic [3:0]   k_dim, l_dim;
    logic         busy, done, error, shake_init, poly_start;
    logic [271:0] poly_seed;
    logic [3:0]   poly_k, poly_l;
    logic         poly_done;

    expand_a_ctrl #(.K(8), .L(7), .SHAKE_RST_CYCLES(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rho        (rho),
        .k_dim      (k_dim),
        .l_dim      (l_dim),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .shake_init (shake_init),
        .poly_start (poly_start),
        .poly_seed  (poly_seed),
        .poly_k     (poly_k),
        .poly_l     (poly_l),
        .poly_done  (poly_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Cycle counter
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub sampler: poly_done stub_lat cycles after poly_start, optionally hangs on one (r,s)
    logic stub_done;
    logic spur_done = 1'b0;
    bit   stub_pend;
    int   stub_cnt;
    int   stub_lat = 10;
    bit   hang_en  = 1'b0;
    int   hang_r   = 0;
    int   hang_s   = 0;
    assign poly_done = stub_done | spur_done;

    always @(posedge clk) begin
        if (rst) begin
            stub_done <= 1'b0;
            stub_pend <= 1'b0;
            stub_cnt  <= 0;
        end else begin
            stub_done <= 1'b0;
            if (poly_start) begin
                if (!(hang_en && int'(poly_k) == hang_r && int'(poly_l) == hang_s)) begin
                    stub_pend <= 1'b1;
                    stub_cnt  <= 1;
                end
            end else if (stub_pend) begin
                if (stub_cnt >= stub_lat - 1) begin
                    stub_done <= 1'b1;
                    stub_pend <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    // Event monitor
    int           ps_n = 0, done_n = 0, err_n = 0, si_n = 0;
    int           done_cyc = 0, err_cyc = 0;
    int           ps_r[512], ps_s[512], ps_cyc[512];
    logic [271:0] ps_seed[512];
    always @(negedge clk) begin
        if (!rst) begin
            if (poly_start) begin
                ps_r[ps_n]    = int'(poly_k);
                ps_s[ps_n]    = int'(poly_l);
                ps_seed[ps_n] = poly_seed;
                ps_cyc[ps_n]  = cyc;
                ps_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (error) begin
                err_n++;
                err_cyc = cyc;
            end
            if (shake_init) si_n++;
        end
    end

    logic [255:0] rho_pat;
    logic [255:0] rho_alt = 256'hC3A5_5A3C_0F1E_2D4B_8796_A5B4_C3D2_E1F0_1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    task automatic pulse_start(input int k, input int l, input logic [255:0] r, output int s_cyc);
        @(negedge clk);
        start = 1'b1;
        k_dim = 4'(k);
        l_dim = 4'(l);
        rho   = r;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; k_dim = '0; l_dim = '0; rho = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, shake_init, poly_start} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, error, shake_init, poly_start});
        end
        checks++;
        if (poly_seed !== '0 || poly_k !== 4'd0 || poly_l !== 4'd0) begin
            failures++;
            $display("FAIL reset_seed: got k=%0d l=%0d seed=%h expected all zero", poly_k, poly_l, poly_seed);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_run();
        int b_ps, b_done, b_err, b_si, s_cyc, nbad;
        bit ok;
        for (int i = 0; i < 32; i++) rho_pat[8*i +: 8] = 8'(i);
        stub_lat = 10;
        b_ps = ps_n; b_done = done_n; b_err = err_n; b_si = si_n;
        pulse_start(4, 4, rho_pat, s_cyc);
        checks++;
        if (busy !== 1'b1 || shake_init !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: got busy=%b shake_init=%b expected 1 1", busy, shake_init);
        end
        wait_idle(2000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout: busy still 1 expected 0");
        end
        checks++;
        if (ps_n - b_ps != 16) begin
            failures++;
            $display("FAIL single_count: got %0d poly_start expected 16", ps_n - b_ps);
        end
        nbad = 0;
        for (int i = 0; i < 16 && b_ps + i < ps_n; i++) begin
            if (ps_r[b_ps+i] != i / 4 || ps_s[b_ps+i] != i % 4 ||
                ps_seed[b_ps+i][271:256] !== 16'(((i / 4) << 8) | (i % 4)) ||
                ps_seed[b_ps+i][255:0] !== rho_pat)
                nbad++;
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL single_order: got %0d bad (r,s)/seed entries expected 0", nbad);
        end
        checks++;
        if (ps_cyc[b_ps] - s_cyc != 3) begin
            failures++;
            $display("FAIL single_first_latency: got %0d expected 3", ps_cyc[b_ps] - s_cyc);
        end
        checks++;
        if (done_n - b_done != 1 || err_n != b_err || done_cyc - s_cyc != 225) begin
            failures++;
            $display("FAIL single_done: got done=%0d err=%0d at +%0d expected 1 0 at +225",
                     done_n - b_done, err_n - b_err, done_cyc - s_cyc);
        end
        checks++;
        if (si_n - b_si != 32) begin
            failures++;
            $display("FAIL single_shake_init: got %0d cycles expected 32", si_n - b_si);
        end
    endtask

    task automatic test_bad_dims();
        int b_ps, b_si, b_err, s_cyc;
        int kv[2] = '{9, 0};
        int lv[2] = '{5, 4};
        b_ps = ps_n; b_si = si_n; b_err = err_n;
        for (int t = 0; t < 2; t++) begin
            pulse_start(kv[t], lv[t], rho_alt, s_cyc);
            checks++;
            if (error !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL bad_dims_%0d: got error=%b busy=%b expected 1 0", t, error, busy);
            end
            @(negedge clk);
            checks++;
            if (error !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL bad_dims_pulse_%0d: got error=%b busy=%b expected 0 0", t, error, busy);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ps_n != b_ps || si_n != b_si || err_n - b_err != 2) begin
            failures++;
            $display("FAIL bad_dims_side: got ps=%0d si=%0d err=%0d expected 0 0 2",
                     ps_n - b_ps, si_n - b_si, err_n - b_err);
        end
    endtask

    task automatic test_watchdog();
        int b_ps, b_done, b_err, s_cyc;
        bit ok;
        stub_lat = 10;
        hang_en = 1'b1; hang_r = 1; hang_s = 2;
        b_ps = ps_n; b_done = done_n; b_err = err_n;
        pulse_start(4, 4, rho_alt, s_cyc);
        wait_idle(2000, ok);
        repeat (3) @(negedge clk);
        hang_en = 1'b0;
        checks++;
        if (!ok || ps_n - b_ps != 7) begin
            failures++;
            $display("FAIL wd_count: got ok=%0d ps=%0d expected 1 7", ok, ps_n - b_ps);
        end
        checks++;
        if (err_n - b_err != 1 || err_cyc - ps_cyc[b_ps+6] != 100) begin
            failures++;
            $display("FAIL wd_error: got err=%0d at +%0d expected 1 at +100",
                     err_n - b_err, err_cyc - ps_cyc[b_ps+6]);
        end
        checks++;
        if (done_n != b_done || busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_nodone: got done=%0d busy=%b expected 0 0", done_n - b_done, busy);
        end
        // Follow-up run must start clean from (0,0)
        b_ps = ps_n; b_done = done_n;
        pulse_start(4, 4, rho_alt, s_cyc);
        wait_idle(2000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || ps_n - b_ps != 16 || ps_r[b_ps] != 0 || ps_s[b_ps] != 0 ||
            ps_r[b_ps+15] != 3 || ps_s[b_ps+15] != 3 || done_n - b_done != 1) begin
            failures++;
            $display("FAIL wd_followup: got ps=%0d first=(%0d,%0d) done=%0d expected 16 (0,0) 1",
                     ps_n - b_ps, ps_r[b_ps], ps_s[b_ps], done_n - b_done);
        end
    endtask

    task automatic test_start_during_wait();
        int b_ps, b_done, s_cyc, s2, nbad;
        bit ok;
        stub_lat = 10;
        b_ps = ps_n; b_done = done_n;
        pulse_start(4, 5, rho_alt, s_cyc);
        for (int i = 0; i < 20 && ps_n == b_ps; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        pulse_start(1, 1, rho_pat, s2);
        wait_idle(3000, ok);
        repeat (2) @(negedge clk);
        nbad = 0;
        for (int i = 0; i < 20 && b_ps + i < ps_n; i++)
            if (ps_r[b_ps+i] != i / 5 || ps_s[b_ps+i] != i % 5 ||
                ps_seed[b_ps+i][255:0] !== rho_alt)
                nbad++;
        checks++;
        if (!ok || ps_n - b_ps != 20 || nbad != 0 || done_n - b_done != 1) begin
            failures++;
            $display("FAIL start_in_wait: got ps=%0d bad=%0d done=%0d expected 20 0 1",
                     ps_n - b_ps, nbad, done_n - b_done);
        end
    endtask

    task automatic test_spurious_done();
        int b_ps, b_done, s_cyc;
        bit ok;
        stub_lat = 10;
        b_ps = ps_n; b_done = done_n;
        pulse_start(1, 2, rho_alt, s_cyc);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        wait_idle(500, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || ps_n - b_ps != 2 || done_n - b_done != 1 || done_cyc - s_cyc != 29) begin
            failures++;
            $display("FAIL spurious_done: got ps=%0d done=%0d at +%0d expected 2 1 at +29",
                     ps_n - b_ps, done_n - b_done, done_cyc - s_cyc);
        end
    endtask

    task automatic test_timeout_edge();
        int b_done, b_err, b_ps, s_cyc;
        bit ok;
        // Done arriving on the timeout cycle is a success
        stub_lat = TO - 1;
        b_done = done_n; b_err = err_n;
        pulse_start(1, 1, rho_alt, s_cyc);
        wait_idle(500, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || done_n - b_done != 1 || err_n != b_err) begin
            failures++;
            $display("FAIL timeout_edge_ok: got done=%0d err=%0d expected 1 0", done_n - b_done, err_n - b_err);
        end
        // One cycle later is too late
        stub_lat = TO;
        b_done = done_n; b_err = err_n; b_ps = ps_n;
        pulse_start(1, 1, rho_alt, s_cyc);
        wait_idle(500, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || done_n != b_done || err_n - b_err != 1 || err_cyc - ps_cyc[b_ps] != 100) begin
            failures++;
            $display("FAIL timeout_edge_late: got done=%0d err=%0d at +%0d expected 0 1 at +100",
                     done_n - b_done, err_n - b_err, err_cyc - ps_cyc[b_ps]);
        end
        stub_lat = 10;
    endtask

    task automatic test_reset_mid_run();
        int b_ps, b_done, b_err, s_cyc;
        bit ok;
        stub_lat = 10;
        b_ps = ps_n; b_done = done_n; b_err = err_n;
        pulse_start(4, 4, rho_alt, s_cyc);
        for (int i = 0; i < 400 && ps_n < b_ps + 12; i++) @(negedge clk);
        checks++;
        if (ps_n != b_ps + 12 || ps_r[b_ps+11] != 2 || ps_s[b_ps+11] != 3) begin
            failures++;
            $display("FAIL rst_mid_reach: got ps=%0d expected 12 ending at (2,3)", ps_n - b_ps);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, error, shake_init, poly_start} !== 5'b0 || poly_seed !== '0 ||
            poly_k !== 4'd0 || poly_l !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got ctrl=%b k=%0d l=%0d expected all zero",
                     {busy, done, error, shake_init, poly_start}, poly_k, poly_l);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_n != b_done || err_n != b_err || ps_n != b_ps + 12) begin
            failures++;
            $display("FAIL rst_mid_quiet: got done=%0d err=%0d ps=%0d expected 0 0 12",
                     done_n - b_done, err_n - b_err, ps_n - b_ps);
        end
        b_ps = ps_n; b_done = done_n;
        pulse_start(4, 4, rho_pat, s_cyc);
        checks++;
        if (shake_init !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart_init: got shake_init=%b busy=%b expected 1 1", shake_init, busy);
        end
        wait_idle(2000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || ps_n - b_ps != 16 || ps_r[b_ps] != 0 || ps_s[b_ps] != 0 ||
            ps_seed[b_ps] !== {16'h0000, rho_pat} || done_n - b_done != 1) begin
            failures++;
            $display("FAIL rst_restart_run: got ps=%0d first=(%0d,%0d) done=%0d expected 16 (0,0) 1",
                     ps_n - b_ps, ps_r[b_ps], ps_s[b_ps], done_n - b_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_bad_dims();
        test_watchdog();
        test_start_during_wait();
        test_spurious_done();
        test_timeout_edge();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/expand_a_ctrl.md
Name: expand_a_ctrl

Overview:
- Sequencer for ExpandA (FIPS 204 Alg. 32) upstream of the rejection-sampling polynomial sampler (RejNTTPoly stage).
- Latches the 32-byte public seed rho and walks r = 0..k_dim-1 (outer loop), s = 0..l_dim-1 (inner loop).
- For each (r,s): re-initialises the SHAKE128 core, builds the 34-byte seed rho||s||r, pulses the sampler and waits for its done.
- Guards each polynomial with a watchdog; reports completion or error for the whole matrix A.

Parameters:
- K, 8, maximum row count supported (ML-DSA-87).
- L, 7, maximum column count supported.
- RHO_BITS, 256, public seed width (shall not modify).
- SEED_BITS, 272, sampler seed width, RHO_BITS+16 (shall not modify).
- SHAKE_RST_CYCLES, 2, cycles shake_init is held high before each polynomial.
- TIMEOUT_CYCLES, 65535, maximum cycles from poly_start to poly_done.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  1-cycle pulse; begin ExpandA
- rho  in  256  public seed, sampled on accepted start
- k_dim  in  4  rows for this run (4/6/8), sampled on accepted start
- l_dim  in  4  columns for this run (4/5/7), sampled on accepted start
- busy  out  1  high from accepted start until done/error
- done  out  1  1-cycle pulse; all k_dim*l_dim polynomials written
- error  out  1  1-cycle pulse; bad dimensions or watchdog expiry
- shake_init  out  1  SHAKE128 sponge state clear
- poly_start  out  1  1-cycle pulse to sampler
- poly_seed  out  272  sampler seed: [255:0]=rho, [263:256]=s, [271:264]=r (byte i at bits 8i+7:8i)
- poly_k  out  4  row index r for sampler address generation
- poly_l  out  4  column index s
- poly_done  in  1  sampler 1-cycle completion pulse

Behaviour:
- Reset values:
  - busy, done, error, shake_init, poly_start = 0.
  - poly_seed, poly_k, poly_l = 0.
  - Internal r/s counters, watchdog and rho latch = 0.
  - State = IDLE.
  - rst mid-run aborts immediately; no done/error is issued.
- All outputs are registered.
- States: IDLE, INIT, LAUNCH, WAIT, ADV, FIN.
- IDLE:
  - start with 1<=k_dim<=K and 1<=l_dim<=L: latch rho/k_dim/l_dim, r=s=0, busy=1, go INIT next cycle.
  - start with bad dims: error pulses the cycle after start; stay IDLE; busy stays 0.
  - start while busy (any non-IDLE state) is ignored.
- INIT:
  - shake_init=1 for exactly SHAKE_RST_CYCLES cycles.
  - poly_seed, poly_k, poly_l are updated to the current (r,s) on entry and are stable before poly_start.
  - Then go LAUNCH.
- LAUNCH: poly_start=1 for one cycle; clear watchdog; go WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - poly_done: go ADV.
  - Watchdog reaches TIMEOUT_CYCLES without poly_done: error pulse, busy=0, go IDLE.
  - poly_done in the same cycle as the timeout counts as success.
- ADV:
  - s==l_dim-1 and r==k_dim-1: go FIN.
  - Else if s==l_dim-1: s=0, r=r+1.
  - Else s=s+1.
  - Then go INIT.
- FIN: done=1 for one cycle; busy=0; go IDLE. A start in the FIN cycle is ignored.
- poly_done outside WAIT is ignored.
- Latency per polynomial: 1 (LAUNCH) + SHAKE_RST_CYCLES + sampler latency + 1 (ADV). Total overhead is (SHAKE_RST_CYCLES+2)*k_dim*l_dim + 2 cycles.
- Counter widths:
  - r and s use 4 bits; they never exceed K-1 / L-1.
  - Watchdog uses $clog2(TIMEOUT_CYCLES+1) bits and saturates (no wrap).
- poly_seed holds its value outside INIT so the sampler may read it at any time during absorb.

Decomposition:
- Shared package dilithium_pkg:
  - Q = 8380417, N = 256.
  - RHO_BITS, SEED_BITS.
  - ML-DSA parameter-set constants (K/L for 44/65/87).
  - State enum type for this FSM.
- No sub-module; the watchdog is an inline counter. The top level instantiates expand_a_ctrl, RejNTTPoly and SHAKE128 side by side.

Test Plan:
- Single run, ML-DSA-44:
  - Stimulus: k_dim=4, l_dim=4, rho=0x00..1F byte pattern; stub sampler returns poly_done 10 cycles after poly_start.
  - Required: exactly 16 poly_start pulses, (r,s) in order (0,0),(0,1)..(3,3); poly_seed[271:256] = {r,s}; poly_seed[255:0] = rho; one done pulse; busy low after.
- ML-DSA-87 with real sampler and SHAKE128:
  - Stimulus: k_dim=8, l_dim=7.
  - Required: 56 polynomials; matrix BRAM matches golden FIPS 204 ExpandA vector for A[0][0][0..3] and A[7][6][252..255].
- Bad dimensions:
  - Stimulus: k_dim=9/l_dim=5, then k_dim=0/l_dim=4.
  - Required: error pulse 1 cycle after each start; no shake_init or poly_start; busy stays 0.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=100; stub never answers on (1,2).
  - Required: error exactly 100 cycles after that poly_start; busy=0; no done.
  - Follow-up: a new start then runs cleanly from (0,0).
- Protocol corners:
  - Stimulus 1: start re-asserted during WAIT. Required: ignored, sequence unchanged.
  - Stimulus 2: spurious poly_done during INIT. Required: ignored.
  - Stimulus 3: poly_done on the timeout cycle. Required: treated as success.
- Reset mid-run:
  - Stimulus: rst asserted during WAIT on poly (2,3).
  - Required: all outputs 0 next cycle; no done/error; a subsequent start restarts at (0,0) with shake_init.
